// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: synchronous-read imem, credit-checked prefetch
// queue, valid/ready handoff to decode, and redirect with flush.
module instr_fetch_unit #(
  parameter int          IW       = 14,
  parameter int          AW       = 5,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_rd_en,
  output logic [AW-1:0]              imem_addr,
  input  logic [IW-1:0]              imem_rdata,
  input  logic                       redirect_valid,
  input  logic [AW-1:0]              redirect_pc,
  output logic                       instr_valid,
  output logic [IW-1:0]              instr,
  output logic [AW-1:0]              instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fetch_pc;
  logic          inflight;
  logic [AW-1:0] inflight_pc;
  logic          squash;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];

  logic          pop;
  logic          push;
  logic          issue;
  logic [CW:0]   credit;

  // Credit counts entries held plus the one response still in flight, minus
  // the head leaving this cycle, so a full queue can still issue on a pop.
  always_comb begin
    pop    = (count != '0) & instr_ready;
    credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    issue  = ~rst & ~redirect_valid & (credit < (CW+1)'(DEPTH));
    push   = inflight & ~squash & ~redirect_valid;
  end

  // ---- stage 0: issue to instruction memory ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= AW'(RESET_PC);
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      inflight <= issue;
      squash   <= redirect_valid & inflight;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      inflight_pc <= fetch_pc;
    end
  end

  // ---- stage 1: response capture into the prefetch queue ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

  // ---- stage 2: queue head presented to decode ----
  always_comb begin
    imem_rd_en  = issue;
    imem_addr   = fetch_pc;
    instr_valid = (count != '0);
    occupancy   = count;
    instr       = instr_valid ? q_instr[rd_ptr] : '0;
    instr_pc    = instr_valid ? q_pc[rd_ptr]    : '0;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Parametrised instruction fetch front-end for the pipelined core. It generalises the bench-side combinational instruction lookup (`instr = mem[pc]`) into a real fetch stage: a synchronous-read instruction memory, a prefetch queue of configurable depth, a valid/ready handshake to decode, and branch/jump redirect with flush. It sits between the instruction memory and the decode stage, replacing the direct `pc`-to-instruction path.

## Interface
- `IW`, default 14: instruction width in bits.
- `AW`, default 5: PC and memory address width in bits.
- `DEPTH`, default 4: prefetch queue entries. Power of two, ≥ 2.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `imem_rd_en`, output, 1: read strobe to the instruction memory.
- `imem_addr`, output, AW: read address. Qualified by `imem_rd_en`.
- `imem_rdata`, input, IW: read data, valid exactly one cycle after the `imem_rd_en` cycle.
- `redirect_valid`, input, 1: branch/jump taken; flush and refetch.
- `redirect_pc`, input, AW: new fetch target. Qualified by `redirect_valid`.
- `instr_valid`, output, 1: queue head holds a valid instruction.
- `instr`, output, IW: queue head instruction.
- `instr_pc`, output, AW: PC of the queue-head instruction.
- `instr_ready`, input, 1: decode accepts the head this cycle.
- `occupancy`, output, $clog2(DEPTH)+1: current queue entry count, 0..DEPTH.

## Operation
- State:
  - `fetch_pc` (AW).
  - `inflight` flag: a read was issued last cycle.
  - `inflight_pc`.
  - `squash` flag.
  - Circular queue of {instr, pc} with read/write pointers and `count`.
- Pop: `pop = instr_valid & instr_ready`. Pop removes the head and advances the read pointer.
- Issue condition: `imem_rd_en = ~redirect_valid & (count + inflight - pop < DEPTH)`. The issue condition is combinational, and this credit check guarantees the queue never overflows.
- On issue:
  - `imem_addr = fetch_pc`.
  - `fetch_pc <= fetch_pc + 1`, modulo 2^AW. The wrap from 2^AW-1 to 0 is legal and silent.
  - `inflight <= 1`, `inflight_pc <= fetch_pc`.
- Response: in the cycle after issue, if `inflight & ~squash & ~redirect_valid`, push {`imem_rdata`, `inflight_pc`} at the write pointer.
- Simultaneous push and pop: both occur, and `count` is unchanged.
- Redirect (`redirect_valid` = 1) in any cycle:
  - Queue is emptied: pointers and `count` return to 0.
  - Any response arriving this cycle is discarded.
  - `fetch_pc <= redirect_pc`.
  - No issue this cycle.
  - Redirect has priority over push, pop and issue. A head popped in the same cycle counts as consumed by decode; the flush does not re-present it.
- Back-to-back redirects: the last one wins. No fetch happens until the first cycle with `redirect_valid` = 0.
- `squash`: reserved for responses returning after a redirect cycle. Because issue is blocked during a redirect, `squash` is set only if a redirect coincides with an outstanding read, and it clears the next cycle.
- Output values:
  - `instr` and `instr_pc` come from the queue head when `instr_valid` = 1, and are 0 when the queue is empty.
  - `instr_valid = (count != 0)`.
  - `occupancy = count`.
- Stall: with `instr_ready` = 0, the head stays stable. The queue fills to DEPTH, then issue stops. No data is lost or duplicated.

## Timing
- Reset (asynchronous, while `rst` = 1):
  - `fetch_pc` = RESET_PC.
  - `imem_rd_en` = 0.
  - `imem_addr` = RESET_PC.
  - `instr_valid` = 0, `instr` = 0, `instr_pc` = 0, `occupancy` = 0.
  - `inflight` = 0, `squash` = 0.
- Reset mid-operation discards the queue and all in-flight responses.
- Startup sequence:
  - First cycle after `rst` falls (C0): `imem_rd_en` = 1, `imem_addr` = RESET_PC.
  - C1: response pushed.
  - C2: `instr_valid` = 1.
- Fetch-to-decode latency is 2 cycles.
- Throughput with `instr_ready` held at 1: one instruction per cycle for any DEPTH ≥ 2.
- Redirect asserted in cycle R:
  - R+1: first issue, at `redirect_pc`.
  - R+2: `instr_valid` = 0.
  - R+3: `instr_valid` = 1 with `instr_pc` = `redirect_pc`.
  - Redirect penalty is 2 bubbles.
- Full queue: with `count` = DEPTH and `pop` = 1, issue occurs in the same cycle (pop credit).

## Test plan
- Reset release, memory word n = n, `instr_ready` = 1:
  - `imem_addr` = 0 in C0.
  - `instr_valid` rises in C2 with `instr_pc` = 0, `instr` = 0.
  - `instr_pc` then increments 1, 2, 3, … every cycle.
- Stall: hold `instr_ready` = 0 from C2:
  - `occupancy` reaches 4 (DEPTH = 4) and `imem_rd_en` drops.
  - Head stays `instr_pc` = 0.
  - On release, PCs 0, 1, 2, 3, 4 appear consecutively with no gaps or duplicates.
- Redirect to 0x1A while the queue holds PCs 5..7:
  - Next cycle: `occupancy` = 0, `instr_valid` = 0.
  - Two cycles after the redirect-plus-1 issue: `instr_pc` = 0x1A, then 0x1B.
  - PC 8 never appears.
- Wrap-around, AW = 5, redirect to 30:
  - Delivered PCs are 30, 31, 0, 1 in order.
- Redirect coinciding with an outstanding response, then a second redirect the next cycle to 3:
  - Only PC 3 onward is delivered.
  - The earlier response is never pushed.
- Assert `rst` while `occupancy` = 3:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - After release, the sequence restarts at RESET_PC with the 2-cycle latency.
